// File: rtl/regfile_wb_arbiter.sv
// Register file write-side arbiter: LSU-priority merge of ALU/LSU results onto one write port, plus busy scoreboard.
// Latency: one cycle from selection to wen_r; ALU results behind the LSU wait in a FIFO_DEPTH-entry FIFO.
// Backpressure: lsu_ready is always 1; alu_ready drops only when the FIFO is full and the LSU holds the port.
module regfile_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int REG_NUM    = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic            iss_ready,
    input  logic [4:0]      iss_rs1,
    input  logic [4:0]      iss_rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,
    output logic            wen_r,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] rin,
    output logic            err_rd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = $clog2(REG_NUM);

    logic [4:0]      fifo_rd   [FIFO_DEPTH];
    logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [AW:0]     count;
    logic [REG_NUM-1:0] busy, busy_next;

    logic            empty, full, alu_xfer, pop, bypass, push;
    logic            sel_vld, wr_next;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    function automatic logic legal(input logic [4:0] r);
        return 32'(r) < REG_NUM;
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign lsu_ready = 1'b1;
    // A full FIFO can still accept when its head drains this cycle (LSU idle).
    assign alu_ready = !full || !lsu_valid;
    assign alu_xfer  = alu_valid && alu_ready;
    assign pop       = !lsu_valid && !empty;
    assign bypass    = !lsu_valid && empty && alu_xfer;
    assign push      = alu_xfer && !bypass;

    assign iss_ready = !(legal(iss_rd)  && busy[iss_rd[RW-1:0]]);
    assign rs1_busy  =   legal(iss_rs1) && busy[iss_rs1[RW-1:0]];
    assign rs2_busy  =   legal(iss_rs2) && busy[iss_rs2[RW-1:0]];

    always_comb begin
        sel_vld  = 1'b0;
        sel_rd   = '0;
        sel_data = '0;
        if (lsu_valid) begin
            sel_vld  = 1'b1;
            sel_rd   = lsu_rd;
            sel_data = lsu_data;
        end else if (pop) begin
            sel_vld  = 1'b1;
            sel_rd   = fifo_rd[rptr];
            sel_data = fifo_data[rptr];
        end else if (bypass) begin
            sel_vld  = 1'b1;
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end
    end

    assign wr_next = sel_vld && (sel_rd != '0) && legal(sel_rd);

    // Clear on the commit edge first so a same-edge re-issue keeps the bit set.
    always_comb begin
        busy_next = busy;
        if (wen_r && legal(rd))
            busy_next[rd[RW-1:0]] = 1'b0;
        if (iss_valid && iss_ready && (iss_rd != '0) && legal(iss_rd))
            busy_next[iss_rd[RW-1:0]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wptr]   <= alu_rd;
            fifo_data[wptr] <= alu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            busy   <= '0;
            wen_r  <= 1'b0;
            rd     <= '0;
            rin    <= '0;
            err_rd <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            busy  <= busy_next;
            wen_r <= wr_next;
            if (wr_next) begin
                rd  <= sel_rd;
                rin <= sel_data;
            end
            if ((iss_valid && iss_ready && !legal(iss_rd)) ||
                (alu_xfer && !legal(alu_rd)) ||
                (lsu_valid && !legal(lsu_rd)))
                err_rd <= 1'b1;
        end
    end
endmodule
